// File: rtl/fp_mul_result_stage.sv
// fp_mul_result_stage: registered FIFO output stage behind combinational fp_mul.
// Buffers {product, overflow, underflow, rounding-mode tag} in a DEPTH-entry
// FIFO, hands entries out over valid/ready, and keeps sticky ov/ud flags.
// Optional build macro: FP_RES_NAN_CANON_EN replaces any NaN product with the
// canonical quiet NaN 32'h7FC0_0000 on push; undefined stores fp_Z bit-exact.
module fp_mul_result_stage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               fp_Z,
  input  logic                       ovrf,
  input  logic                       udrf,
  input  logic [2:0]                 r_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_result,
  output logic                       out_ovrf,
  output logic                       out_udrf,
  output logic [2:0]                 out_rmode,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       flag_clr,
  output logic                       sticky_ov,
  output logic                       sticky_ud
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned EntW = W + 5;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            sticky_ov_q, sticky_ov_d;
  logic            sticky_ud_q, sticky_ud_d;
  logic [W-1:0]    store_z;
  logic [EntW-1:0] head;
  logic            push, pop;

  // Handshakes; both sides are held off while reset is asserted.
  always_comb begin
    in_ready  = rst_n && (count_q != CntFull);
    out_valid = rst_n && (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Value actually written into storage (optionally NaN-canonicalised).
  always_comb begin
    store_z = fp_Z;
`ifdef FP_RES_NAN_CANON_EN
    if ((fp_Z[30:23] == 8'hFF) && (fp_Z[22:0] != 23'd0)) begin
      store_z = W'(32'h7FC0_0000);
    end
`endif
  end

  // Next-state for pointers, occupancy and sticky flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // A same-cycle set wins over clear so no event is lost.
    sticky_ov_d = (sticky_ov_q && !flag_clr) || (push && ovrf);
    sticky_ud_d = (sticky_ud_q && !flag_clr) || (push && udrf);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sticky_ov_q <= 1'b0;
      sticky_ud_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sticky_ov_q <= sticky_ov_d;
      sticky_ud_q <= sticky_ud_d;
    end
  end

  // Entry storage; not reset, reset only discards entries via the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {store_z, ovrf, udrf, r_mode};
  end

  // Head outputs come straight from storage, forced to zero during reset.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_result = '0;
    out_ovrf   = 1'b0;
    out_udrf   = 1'b0;
    out_rmode  = '0;
    if (rst_n) begin
      out_result = head[EntW-1:5];
      out_ovrf   = head[4];
      out_udrf   = head[3];
      out_rmode  = head[2:0];
    end
  end

  assign count     = count_q;
  assign sticky_ov = sticky_ov_q;
  assign sticky_ud = sticky_ud_q;

endmodule
